// File: rtl/peripheral_dbg_soc_dii_channel.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_dbg_soc_dii_channel (package)
//  Description : Shared DII channel flit type. A flit carries a valid flag,
//                an end-of-packet marker and a 16-bit data word.
//  Revision    : 1.0 - initial release
// ============================================================================
package peripheral_dbg_soc_dii_channel;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage : peripheral_dbg_soc_dii_channel
`default_nettype wire

// File: rtl/peripheral_dbg_soc_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_dbg_soc_rr_select
//  Description : Combinational round-robin selector. Scans the request
//                vector starting at i_prio_ptr, wrapping modulo PORTS, and
//                returns the first requester as a one-hot grant plus index.
//  Ports       : i_req        - one request bit per port
//                i_prio_ptr   - port with highest priority this cycle
//                o_grant      - one-hot grant (all zero if no request)
//                o_grant_idx  - index of the granted port (0 if none)
//                o_grant_valid- at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module peripheral_dbg_soc_rr_select #(
    parameter int PORTS = 2,
    parameter int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic [PORTS-1:0] i_req,
    input  logic [PTR_W-1:0] i_prio_ptr,
    output logic [PORTS-1:0] o_grant,
    output logic [PTR_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    always_comb begin : p_search
        int   w_idx;
        logic w_found;
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int k = 0; k < PORTS; k++) begin
            w_idx = (int'(i_prio_ptr) + k) % PORTS;
            if (!w_found && i_req[w_idx]) begin
                w_found          = 1'b1;
                o_grant[w_idx]   = 1'b1;
                o_grant_idx      = PTR_W'(w_idx);
            end
        end
        o_grant_valid = w_found;
    end

endmodule : peripheral_dbg_soc_rr_select
`default_nettype wire

// File: rtl/peripheral_dbg_soc_dii_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_dbg_soc_dii_packet_arbiter
//  Description : Packet-aware round-robin arbiter merging PORTS DII flit
//                streams onto one registered DII output. A granted packet
//                holds the output until its last flit; packets are never
//                interleaved.
//  Ports       : clk, rst     - clock, asynchronous active-high reset
//                in_flit      - input flits, one per port
//                in_ready     - per-port accept
//                out_flit     - registered output flit
//                out_ready    - downstream accept
//                busy         - a multi-flit packet holds the lock
//                active_port  - locked port, or last granted port when idle
//  Revision    : 1.0 - initial release
// ============================================================================
module peripheral_dbg_soc_dii_packet_arbiter
    import peripheral_dbg_soc_dii_channel::*;
#(
    parameter  int PORTS = 2,
    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  dii_flit [PORTS-1:0]  in_flit,
    output logic    [PORTS-1:0]  in_ready,
    output dii_flit              out_flit,
    input  logic                 out_ready,
    output logic                 busy,
    output logic    [PTR_W-1:0]  active_port
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_LOCKED = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [PTR_W-1:0] r_prio_ptr;
    logic [PTR_W-1:0] r_lock_port;
    logic [PTR_W-1:0] r_active_port;
    dii_flit          r_out_flit;

    logic [PORTS-1:0] w_req;
    logic [PORTS-1:0] w_grant;
    logic [PTR_W-1:0] w_grant_idx;
    logic             w_grant_valid;
    logic             w_stage_free;
    logic [PTR_W-1:0] w_sel_port;
    dii_flit          w_sel_flit;
    logic             w_accept;
    logic [PTR_W-1:0] w_next_ptr;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_req
            assign w_req[gi] = in_flit[gi].valid;
        end
    endgenerate

    peripheral_dbg_soc_rr_select #(
        .PORTS (PORTS),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .i_req         (w_req),
        .i_prio_ptr    (r_prio_ptr),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // The output register may take a new flit when it is empty or being drained.
    assign w_stage_free = !r_out_flit.valid || out_ready;

    // In LOCKED the source is pinned to the lock owner; in IDLE it follows the
    // round-robin grant. An IDLE accept requires a real request, a LOCKED one
    // requires the owner's flit to be valid (bubbles simply stall the packet).
    always_comb begin
        w_sel_port = (r_state == c_ST_LOCKED) ? r_lock_port : w_grant_idx;
        w_sel_flit = in_flit[w_sel_port];
        w_accept   = w_stage_free &&
                     ((r_state == c_ST_LOCKED) ? w_sel_flit.valid : w_grant_valid);
        w_next_ptr = (w_sel_port == PTR_W'(PORTS - 1)) ? '0 : (w_sel_port + PTR_W'(1));
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept && !w_sel_flit.last) begin
                    w_state_nxt = c_ST_LOCKED;
                end
            end
            c_ST_LOCKED: begin
                if (w_accept && w_sel_flit.last) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // While locked the owner sees ready even without valid, so its packet
    // keeps the link through bubbles.
    always_comb begin
        in_ready = '0;
        busy     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                in_ready = w_grant & {PORTS{w_stage_free}};
            end
            c_ST_LOCKED: begin
                busy                  = 1'b1;
                in_ready[r_lock_port] = w_stage_free;
            end
            default: begin
                in_ready = '0;
                busy     = 1'b0;
            end
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_flit    <= '0;
            r_prio_ptr    <= '0;
            r_lock_port   <= '0;
            r_active_port <= '0;
        end else begin
            if (w_stage_free) begin
                if (w_accept) begin
                    r_out_flit <= w_sel_flit;
                end else begin
                    r_out_flit.valid <= 1'b0;
                end
            end
            if (w_accept) begin
                r_active_port <= w_sel_port;
                if (r_state == c_ST_IDLE && !w_sel_flit.last) begin
                    r_lock_port <= w_sel_port;
                end
                // Priority moves past the owner only at a packet boundary.
                if (w_sel_flit.last) begin
                    r_prio_ptr <= w_next_ptr;
                end
            end
        end
    end

    assign out_flit    = r_out_flit;
    assign active_port = r_active_port;

endmodule : peripheral_dbg_soc_dii_packet_arbiter
`default_nettype wire

// File: tb/tb_peripheral_dbg_soc_dii_packet_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peripheral_dbg_soc_dii_packet_arbiter
//  Description : Directed self-checking bench for the DII packet arbiter
//                with three ports. Sources are per-port flit queues popped on
//                handshake; output flits are collected and compared against
//                hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_dbg_soc_dii_packet_arbiter;
    import peripheral_dbg_soc_dii_channel::*;

    localparam int PORTS = 3;

    logic                clk = 1'b0;
    logic                rst;
    dii_flit [PORTS-1:0] in_flit;
    logic    [PORTS-1:0] in_ready;
    dii_flit             out_flit;
    logic                out_ready;
    logic                busy;
    logic    [1:0]       active_port;

    peripheral_dbg_soc_dii_packet_arbiter #(
        .PORTS (PORTS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_flit     (in_flit),
        .in_ready    (in_ready),
        .out_flit    (out_flit),
        .out_ready   (out_ready),
        .busy        (busy),
        .active_port (active_port)
    );

    always #5 clk = ~clk;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               idle_viol = 0;
    dii_flit          src_q [PORTS][$];
    logic [15:0]      got_q [$];
    logic [15:0]      exp_q [$];
    logic [PORTS-1:0] hold;
    logic [PORTS-1:0] smp_rdy;
    logic             smp_busy;
    dii_flit          smp_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic dii_flit mk(input logic l, input logic [15:0] d);
        dii_flit f;
        f.valid = 1'b1;
        f.last  = l;
        f.data  = d;
        return f;
    endfunction

    // One clock: present queue heads, sample at negedge, pop accepted flits.
    task automatic cycle();
        logic [PORTS-1:0] v;
        for (int i = 0; i < PORTS; i++) begin
            in_flit[i] = (src_q[i].size() > 0 && !hold[i]) ? src_q[i][0] : '0;
        end
        @(negedge clk);
        smp_rdy  = in_ready;
        smp_busy = busy;
        smp_out  = out_flit;
        for (int i = 0; i < PORTS; i++) v[i] = in_flit[i].valid;
        if (!busy && ((in_ready & ~v) != '0)) idle_viol++;
        if (out_flit.valid && out_ready) got_q.push_back(out_flit.data);
        @(posedge clk);
        #1;
        for (int i = 0; i < PORTS; i++) begin
            if (v[i] && smp_rdy[i]) void'(src_q[i].pop_front());
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        hold      = '0;
        out_ready = 1'b1;
        in_flit   = '0;
        for (int i = 0; i < PORTS; i++) src_q[i].delete();
        got_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_seq(input string tag);
        check($sformatf("%s_count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d]", tag, i),
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD_BEEF, 32'(exp_q[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        check("rst_out_valid", 32'(out_flit.valid), 32'd0);
        check("rst_out_last",  32'(out_flit.last),  32'd0);
        check("rst_out_data",  32'(out_flit.data),  32'd0);
        check("rst_busy",      32'(busy),           32'd0);
        check("rst_active",    32'(active_port),    32'd0);
        check("rst_in_ready",  32'(in_ready),       32'd0);

        // ---------------- single-flit round robin ----------------
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < PORTS; p++) src_q[p].push_back(mk(1'b1, 16'hA000 + 16'(p)));
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (k < 9) check($sformatf("rr_rdy%0d", k), 32'(smp_rdy), 32'(3'b001 << (k % 3)));
            if (k == 0) check("rr_latency0", 32'(got_q.size()), 32'd0);
            if (k >= 1) check($sformatf("rr_tput%0d", k), 32'(got_q.size()), 32'(k));
        end
        exp_q = '{16'hA000, 16'hA001, 16'hA002, 16'hA000, 16'hA001, 16'hA002,
                  16'hA000, 16'hA001, 16'hA002};
        check_seq("rr_seq");

        // ---------------- no interleaving ----------------
        do_reset();
        src_q[0].push_back(mk(1'b0, 16'h0001));
        src_q[0].push_back(mk(1'b0, 16'h0002));
        src_q[0].push_back(mk(1'b0, 16'h0003));
        src_q[0].push_back(mk(1'b1, 16'h0004));
        src_q[1].push_back(mk(1'b1, 16'h1001));
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k < 4)  check($sformatf("nil_rdy%0d", k), 32'(smp_rdy), 32'(3'b001));
            if (k == 4) check("nil_rdy4", 32'(smp_rdy), 32'(3'b010));
            if (k == 2) check("nil_busy", 32'(smp_busy), 32'd1);
            if (k == 4) check("nil_busy_end", 32'(smp_busy), 32'd0);
        end
        exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h1001};
        check_seq("nil_seq");

        // ---------------- bubble in locked packet ----------------
        do_reset();
        src_q[0].push_back(mk(1'b0, 16'h0001));
        src_q[0].push_back(mk(1'b0, 16'h0002));
        src_q[0].push_back(mk(1'b1, 16'h0003));
        src_q[1].push_back(mk(1'b1, 16'h1001));
        cycle();
        hold = 3'b001;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("bub_rdy%0d", k),  32'(smp_rdy),  32'(3'b001));
            check($sformatf("bub_busy%0d", k), 32'(smp_busy), 32'd1);
        end
        hold = '0;
        repeat (4) cycle();
        exp_q = '{16'h0001, 16'h0002, 16'h0003, 16'h1001};
        check_seq("bub_seq");

        // ---------------- fairness after multi-flit packet ----------------
        do_reset();
        src_q[1].push_back(mk(1'b0, 16'h1001));
        src_q[1].push_back(mk(1'b1, 16'h1002));
        src_q[0].push_back(mk(1'b1, 16'h0001));
        src_q[2].push_back(mk(1'b1, 16'h2001));
        hold = 3'b101;
        cycle();
        check("fair_rdy0", 32'(smp_rdy), 32'(3'b010));
        check("fair_active0", 32'(active_port), 32'd1);
        hold = '0;
        cycle();
        check("fair_rdy1", 32'(smp_rdy), 32'(3'b010));
        cycle();
        check("fair_rdy2", 32'(smp_rdy), 32'(3'b100));
        check("fair_active2", 32'(active_port), 32'd2);
        cycle();
        check("fair_rdy3", 32'(smp_rdy), 32'(3'b001));
        check("fair_active3", 32'(active_port), 32'd0);
        cycle();
        exp_q = '{16'h1001, 16'h1002, 16'h2001, 16'h0001};
        check_seq("fair_seq");

        // ---------------- backpressure ----------------
        do_reset();
        src_q[0].push_back(mk(1'b1, 16'h0BEE));
        src_q[0].push_back(mk(1'b1, 16'h0001));
        src_q[1].push_back(mk(1'b1, 16'h1001));
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("bp_rdy%0d", k),   32'(smp_rdy),       32'd0);
            check($sformatf("bp_valid%0d", k), 32'(smp_out.valid), 32'd1);
            check($sformatf("bp_data%0d", k),  32'(smp_out.data),  32'h0BEE);
        end
        out_ready = 1'b1;
        repeat (4) cycle();
        exp_q = '{16'h0BEE, 16'h1001, 16'h0001};
        check_seq("bp_seq");

        // ---------------- reset mid-packet ----------------
        do_reset();
        src_q[1].push_back(mk(1'b0, 16'h1001));
        src_q[1].push_back(mk(1'b0, 16'h1002));
        src_q[1].push_back(mk(1'b1, 16'h1003));
        src_q[0].push_back(mk(1'b1, 16'h0001));
        hold = 3'b001;
        cycle();
        check("mid_busy_pre",   32'(busy),        32'd1);
        check("mid_active_pre", 32'(active_port), 32'd1);
        check("mid_valid_pre",  32'(out_flit.valid), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid",  32'(out_flit.valid), 32'd0);
        check("mid_rst_busy",   32'(busy),           32'd0);
        check("mid_rst_active", 32'(active_port),    32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        hold = '0;
        cycle();
        check("mid_post_rdy", 32'(smp_rdy), 32'(3'b001));
        cycle();
        check("mid_post_cnt", 32'(got_q.size()), 32'd1);
        check("mid_post_data", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD_BEEF, 32'h0001);

        check("idle_ready_without_valid", 32'(idle_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_peripheral_dbg_soc_dii_packet_arbiter
`default_nettype wire
